// File: rtl/snitch_icache_perf_counters.sv
// snitch_icache_perf_counters: saturating instruction-cache event counters with a 1-cycle indexed read port.
// Optional macro SNITCH_ICACHE_PERF_PIPE_EN registers the event inputs once before accumulation.

package snitch_icache_perf_pkg;
  localparam int unsigned L0_EV_W = 5;
  localparam int unsigned L1_EV_W = 6;
  localparam int unsigned NR_CNT  = L0_EV_W + L1_EV_W;

  // Field order puts counter k at bit k of each vector.
  typedef struct packed {
    logic l0_stall;
    logic l0_double_hit;
    logic l0_prefetch;
    logic l0_hit;
    logic l0_miss;
  } icache_l0_events_t;

  typedef struct packed {
    logic l1_data_parity_error;
    logic l1_tag_parity_error;
    logic l1_handler_stall;
    logic l1_stall;
    logic l1_hit;
    logic l1_miss;
  } icache_l1_events_t;
endpackage

module snitch_icache_perf_counters
  import snitch_icache_perf_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 2,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  icache_l0_events_t [NR_FETCH_PORTS-1:0]  l0_events_i,
  input  icache_l1_events_t                       l1_events_i,
  input  logic                                    enable_i,
  input  logic                                    clear_i,
  input  logic                                    rd_req_i,
  input  logic [3:0]                              rd_idx_i,
  output logic                                    rd_valid_o,
  output logic [CNT_W-1:0]                        rd_data_o,
  output logic                                    rd_err_o,
  output logic [NR_CNT-1:0]                       ovf_o
);

  localparam int unsigned      SUM_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NR_FETCH_PORTS-1:0][L0_EV_W-1:0] l0_ev;
  logic [L1_EV_W-1:0]                     l1_ev;
  logic                                   en;

`ifdef SNITCH_ICACHE_PERF_PIPE_EN
  // Clear also flushes this stage, so events captured alongside a clear never land.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      l0_ev <= '0;
      l1_ev <= '0;
      en    <= 1'b0;
    end else if (clear_i) begin
      l0_ev <= '0;
      l1_ev <= '0;
      en    <= 1'b0;
    end else begin
      l0_ev <= l0_events_i;
      l1_ev <= l1_events_i;
      en    <= enable_i;
    end
  end
`else
  assign l0_ev = l0_events_i;
  assign l1_ev = l1_events_i;
  assign en    = enable_i;
`endif

  logic [SUM_W-1:0] inc [NR_CNT];
  logic [SUM_W-1:0] sum [NR_CNT];
  logic [CNT_W-1:0] cnt_q [NR_CNT];
  logic [NR_CNT-1:0] ovf_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    for (int k = 0; k < NR_CNT; k++) inc[k] = '0;
    for (int k = 0; k < L0_EV_W; k++) begin
      for (int p = 0; p < NR_FETCH_PORTS; p++) begin
        inc[k] = inc[k] + SUM_W'(l0_ev[p][k]);
      end
    end
    for (int k = 0; k < L1_EV_W; k++) inc[L0_EV_W+k] = SUM_W'(l1_ev[k]);
  end

  always_comb begin
    for (int k = 0; k < NR_CNT; k++) sum[k] = {1'b0, cnt_q[k]} + inc[k];
  end

  // NOTE: the counter array is architectural state read by software, so each element is reset;
  // non-blocking assignments keep every counter updating from the same pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NR_CNT; k++) cnt_q[k] <= '0;
      ovf_q <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < NR_CNT; k++) cnt_q[k] <= '0;
      ovf_q <= '0;
    end else if (en) begin
      for (int k = 0; k < NR_CNT; k++) begin
        if (sum[k][CNT_W]) begin
          cnt_q[k] <= CNT_MAX;
          ovf_q[k] <= 1'b1;
        end else begin
          cnt_q[k] <= sum[k][CNT_W-1:0];
        end
      end
    end
  end

  assign ovf_o = ovf_q;

  // Read mux yields zero for indices past the last counter.
  logic [CNT_W-1:0] rd_mux;
  logic             rd_oob;

  assign rd_oob = (rd_idx_i >= 4'(NR_CNT));

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NR_CNT; k++) begin
      if (rd_idx_i == 4'(k)) rd_mux = cnt_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      rd_err_o   <= 1'b0;
    end else begin
      rd_valid_o <= rd_req_i;
      if (rd_req_i) begin
        rd_data_o <= rd_mux;
        rd_err_o  <= rd_oob;
      end
    end
  end

endmodule
